// File: rtl/pipeline_sink.sv
// Four-phase handshake sink that captures one byte per DIR-high phase into a small FIFO.
// Optional running XOR checksum of accepted bytes, enabled by defining PIPELINE_SINK_CHECKSUM_EN.
module pipeline_sink #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     DIR,
  input  logic [7:0]               data_in,
  output logic                     ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               checksum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACKING = 1'b1
  } state_t;

  logic [1:0]    sync_reg;
  logic          run;
  state_t        state_reg;
  logic          ack_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    mem [DEPTH];
  logic          full;
  logic          push;
  logic          pop;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign run  = sync_reg[1];
  assign full = (count_reg == FULL_COUNT);
  // Full is judged before any same-cycle pop, so a pop never makes room for a push that edge.
  assign push = run && (state_reg == IDLE) && DIR && !full;
  assign pop  = run && (count_reg != '0) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else if (run) begin
      case (state_reg)
        IDLE: begin
          if (DIR && !full) begin
            state_reg <= ACKING;
            ack_reg   <= 1'b1;
          end else begin
            ack_reg   <= 1'b0;
          end
        end
        ACKING: begin
          if (!DIR) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
          end else begin
            ack_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

`ifdef PIPELINE_SINK_CHECKSUM_EN
  logic [7:0] checksum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_reg <= 8'h00;
    end else if (push) begin
      checksum_reg <= checksum_reg ^ data_in;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 8'h00;
`endif

  assign ack       = ack_reg;
  assign count     = count_reg;
  assign out_valid = (count_reg != '0);
  // Gating on out_valid keeps out_data at zero through reset without clearing storage.
  assign out_data  = out_valid ? mem[rd_ptr_reg] : 8'h00;

endmodule
